// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types and helpers for the weighted round-robin arbiter
//
// Purpose: FSM state encoding plus the constant/helper functions used by
//          arbiter_wrr_pipeline and rr_pick.
// Contents: arb_state_t (IDLE=0, BURST=1), clog2(value), inc_mod(x, n).
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // (x + 1) mod n for 0 <= x < n, without a divider.
  function automatic int inc_mod(input int x, input int n);
    return (x + 1 >= n) ? 0 : x + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority encoder
//
// Purpose: returns the first set bit of req scanning ptr, ptr+1, ... cyclically.
// Ports:
//   req  [N]  - request vector
//   ptr  [IW] - highest-priority index, must be < N
//   any       - at least one request is set
//   idx  [IW] - winning index (0 when any is low)
module rr_pick
  import arbiter_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = (clog2(N) > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Lower half keeps only requests at or above ptr; upper half keeps all of
  // them. The lowest set bit of the doubled vector is the cyclic winner, and
  // a hit in the upper half means the scan wrapped past N-1.
  logic [2*N-1:0] dbl;
  logic [IW:0]    pos;

  always_comb begin
    dbl = '0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      dbl[i]     = req[i] & (i >= int'(ptr));
      dbl[N + i] = req[i];
    end
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) pos = (IW + 1)'(i);
    end
    any = |req;
    idx = (pos >= (IW + 1)'(N)) ? IW'(pos - (IW + 1)'(N)) : IW'(pos);
  end

endmodule

// File: rtl/arbiter_wrr_pipeline.sv
// rtl/arbiter_wrr_pipeline.sv - weighted round-robin packet arbiter with registered output
//
// Purpose: merges bus_num valid/ready packet streams into one. A grant covers
//          whole packets and lasts for up to weight_in[owner] packets.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   valid_in/last_in [N]   - per-channel beat valid and end-of-packet
//   data_in  [N*DW]        - channel i at [DW*(i+1)-1 -: DW]
//   weight_in [N*WW]       - per-channel packet quantum (0 behaves as 1)
//   ready_out [N]          - per-channel ready, only the owner's bit can be set
//   valid_out/data_out/last_out/id_out - registered output beat and source index
//   ready_in               - downstream ready
module arbiter_wrr_pipeline
  import arbiter_pkg::*;
#(
  parameter  int bus_num = 8,
  parameter  int DW      = 8,
  parameter  int WW      = 4,
  localparam int IW      = (clog2(bus_num) > 1) ? clog2(bus_num) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [bus_num-1:0]    valid_in,
  input  logic [bus_num*DW-1:0] data_in,
  input  logic [bus_num-1:0]    last_in,
  input  logic [bus_num*WW-1:0] weight_in,
  output logic [bus_num-1:0]    ready_out,
  output logic                  valid_out,
  output logic [DW-1:0]         data_out,
  output logic                  last_out,
  output logic [IW-1:0]         id_out,
  input  logic                  ready_in
);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] owner, owner_nxt, owner_inc;
  logic [WW-1:0] credit, credit_nxt;
  logic          mid, mid_nxt;

  logic          load;
  logic          xfer;
  logic          own_valid;
  logic          own_last;
  logic [DW-1:0] own_data;
  logic [WW-1:0] win_weight;
  logic          pick_any;
  logic [IW-1:0] pick_idx;

  rr_pick #(.N(bus_num)) u_pick (
    .req (valid_in),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // The output register can take a new beat when empty or being drained.
  // This makes ready_in -> ready_out combinational.
  assign load      = ~valid_out | ready_in;
  assign owner_inc = IW'(inc_mod(int'(owner), bus_num));
  assign xfer      = (state == BURST) & own_valid & load;

  always_comb begin
    own_valid  = 1'b0;
    own_last   = 1'b0;
    own_data   = '0;
    win_weight = '0;
    for (int i = 0; i < bus_num; i++) begin
      if (owner == IW'(i)) begin
        own_valid = valid_in[i];
        own_last  = last_in[i];
        own_data  = data_in[DW*i +: DW];
      end
      if (pick_idx == IW'(i)) win_weight = weight_in[WW*i +: WW];
    end
  end

  always_comb begin
    ready_out = '0;
    if (state == BURST) begin
      for (int i = 0; i < bus_num; i++) begin
        if (owner == IW'(i)) ready_out[i] = load;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    owner_nxt  = owner;
    credit_nxt = credit;
    mid_nxt    = mid;
    case (state)
      IDLE: begin
        if (pick_any) begin
          owner_nxt  = pick_idx;
          credit_nxt = (win_weight == '0) ? WW'(1) : win_weight;
          mid_nxt    = 1'b0;
          state_nxt  = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          if (own_last) begin
            mid_nxt    = 1'b0;
            credit_nxt = credit - WW'(1);
            if (credit == WW'(1)) begin
              ptr_nxt   = owner_inc;
              state_nxt = IDLE;
            end
          end else begin
            mid_nxt = 1'b1;
          end
        end else if (!mid && !own_valid) begin
          // Owner has nothing pending between packets: give up the rest of
          // the quantum. Inside a packet (mid) the grant is always held.
          ptr_nxt   = owner_inc;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      credit <= '0;
      mid    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      owner  <= owner_nxt;
      credit <= credit_nxt;
      mid    <= mid_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
      id_out    <= '0;
    end else if (load) begin
      valid_out <= xfer;
      if (xfer) begin
        data_out <= own_data;
        last_out <= own_last;
        id_out   <= owner;
      end
    end
  end

endmodule
